fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage for the 8-bit nrisc core, sitting directly upstream of the unified 8-bit memory.
- Owns the program counter.
- Drives the memory address and read-enable for instruction reads.
- Captures the returned instruction byte into an instruction register.
- Hands the instruction to decode over a valid/ready handshake.
- Supports halt freeze, branch redirect, data-stage bus priority, and a sticky fault for fetches outside the instruction region.

Parameters:
ADDR_WIDTH, 8, width of PC and memory address.
DATA_WIDTH, 8, instruction byte width.
RESET_PC, 8'h00, PC value after reset.
INSTR_LIMIT, 8'h8B, highest legal instruction address; 8'h8C and above is the data region.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
halt  input  1  freezes all state; fetch unit drives no memory read while high.
mem_busy  input  1  data stage owns the memory this cycle; no fetch read may be issued.
redirect  input  1  branch/jump taken; load redirect_pc and flush.
redirect_pc  input  ADDR_WIDTH  branch target.
instr_ready  input  1  decode accepts instr_out this cycle.
mem_instr  input  DATA_WIDTH  instruction byte from memory, valid by the posedge after a read cycle.
mem_addr  output  ADDR_WIDTH  memory address; equals pc (combinational).
mem_read  output  1  instruction read strobe (combinational).
instr_out  output  DATA_WIDTH  instruction register.
instr_valid  output  1  instr_out holds an unconsumed instruction.
instr_pc  output  ADDR_WIDTH  address instr_out was fetched from.
fetch_count  output  8  number of instructions accepted by decode, mod 256.
fault  output  1  sticky: fetch target exceeded INSTR_LIMIT.

Behaviour:
Reset values (reset sampled at posedge):
- pc = RESET_PC; instr_out = 0; instr_pc = 0; instr_valid = 0; fetch_count = 0; fault = 0.
- State = FETCH.
- Reset overrides every other input.

State machine (FETCH, HOLD, FAULT):
- FETCH:
  - mem_read = 1 iff !halt && !mem_busy && !reset.
  - When mem_read = 1 at a posedge: instr_out <= mem_instr; instr_pc <= pc; instr_valid <= 1; pc <= pc+1 (pc == INSTR_LIMIT wraps to 8'h00); state <= HOLD.
  - Latency: 1 cycle from mem_read high to instr_valid high.
  - mem_busy high: remain in FETCH, no state change, retry next cycle.
- HOLD:
  - mem_read = 0; instr_valid = 1; instr_out stable.
  - instr_ready at posedge: fetch_count <= fetch_count+1 (wraps 255 -> 0); instr_valid <= 0; state <= FETCH.
  - Throughput: 1 instruction per 2 cycles minimum.
- FAULT:
  - mem_read = 0; instr_valid = 0; fault = 1.
  - Leaves only on reset. redirect and instr_ready are ignored.

Priority, highest first: reset > halt > redirect > normal FSM.
- halt high: no register changes at all (pc, IR, count, state held); mem_read forced 0; instr_valid keeps its value, but a handshake is not honoured (count not incremented) while halted.
- redirect (not halted), in FETCH or HOLD:
  - instr_valid <= 0, discarding any held instruction; no fetch_count increment, even if instr_ready is high the same cycle.
  - Any fetch completing the same cycle is discarded.
  - redirect_pc <= INSTR_LIMIT: pc <= redirect_pc; state <= FETCH.
  - redirect_pc > INSTR_LIMIT: fault <= 1; state <= FAULT; pc unchanged.
- mem_addr always equals pc, regardless of mem_read.

Test Plan:
- Reset then run with instr_ready=1, memory 0x00..0x03 = A1,B2,C3,D4: instr_out sequence A1,B2,C3,D4 with instr_pc 0..3; instr_valid high every second cycle; fetch_count = 4.
- PC at 8'h8B, fetch completes: instr_pc = 8'h8B, next mem_addr = 8'h00, no fault.
- Hold instr_ready=0 for 5 cycles in HOLD: instr_out and instr_valid stable, mem_read = 0; assert instr_ready -> fetch_count +1, fetch resumes.
- mem_busy=1 for 3 cycles in FETCH: mem_read = 0, pc unchanged; first free cycle fetches at the same address.
- In HOLD, redirect=1, redirect_pc=8'h40, instr_ready=1: instr_valid -> 0, count unchanged, next mem_addr = 8'h40. Repeat with redirect_pc=8'h90: fault = 1, mem_read stays 0 until reset.
- Assert halt mid-HOLD for 4 cycles with instr_ready=1: no count change, all outputs frozen; deassert -> handshake completes. Then assert reset while in FAULT: all outputs return to reset values, next cycle fetches RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// nrisc fetch stage: owns the PC, reads instruction bytes from the
// unified memory and hands them to decode over valid/ready.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [ADDR_WIDTH-1:0] INSTR_LIMIT = 'h8B
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  halt,
  input  logic                  mem_busy,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  instr_ready,
  input  logic [DATA_WIDTH-1:0] mem_instr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [7:0]            fetch_count,
  output logic                  fault
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_FAULT
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   ir_q, ir_d;
  logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
  logic                    valid_q, valid_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    fault_q, fault_d;

  logic                    fetch_go;
  logic                    tgt_ok;
  logic [ADDR_WIDTH-1:0]   pc_inc;

  assign fetch_go = (state_q == S_FETCH) && !halt
                    && !mem_busy && !reset;
  assign tgt_ok   = (redirect_pc <= INSTR_LIMIT);
  // The instruction region is circular: the last legal byte
  // is followed by address zero, never by the data region.
  assign pc_inc   = (pc_q == INSTR_LIMIT) ? '0
                    : pc_q + 1'b1;

  assign mem_addr    = pc_q;
  assign mem_read    = fetch_go;
  assign instr_out   = ir_q;
  assign instr_valid = valid_q;
  assign instr_pc    = ipc_q;
  assign fetch_count = cnt_q;
  assign fault       = fault_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;

    if (halt) begin
      state_d = state_q;
    end else if (redirect && state_q != S_FAULT) begin
      valid_d = 1'b0;
      if (tgt_ok) begin
        pc_d    = redirect_pc;
        state_d = S_FETCH;
      end else begin
        fault_d = 1'b1;
        state_d = S_FAULT;
      end
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (fetch_go) begin
            ir_d    = mem_instr;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_inc;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            cnt_d   = cnt_q + 8'd1;
            valid_d = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run
// against a rule-level model of the fetch stage.
module tb_fetch_unit;

  logic       clock;
  logic       reset;
  logic       halt;
  logic       mem_busy;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       instr_ready;
  logic [7:0] mem_instr;
  logic [7:0] mem_addr;
  logic       mem_read;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic [7:0] instr_pc;
  logic [7:0] fetch_count;
  logic       fault;

  logic [7:0] mem [256];

  int n_vec;
  int n_err;

  // reference model
  logic [7:0] m_pc, m_ir, m_ipc, m_cnt;
  logic       m_valid, m_fault;

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .halt        (halt),
    .mem_busy    (mem_busy),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_ready (instr_ready),
    .mem_instr   (mem_instr),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .fetch_count (fetch_count),
    .fault       (fault)
  );

  assign mem_instr = mem[mem_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    if (reset) begin
      m_pc = 8'h00; m_ir = 8'h00; m_ipc = 8'h00;
      m_cnt = 8'h00; m_valid = 1'b0; m_fault = 1'b0;
    end else if (!halt && !m_fault) begin
      if (redirect) begin
        m_valid = 1'b0;
        if (redirect_pc <= 8'h8B) m_pc = redirect_pc;
        else m_fault = 1'b1;
      end else if (!m_valid) begin
        if (!mem_busy) begin
          m_ir = mem[m_pc];
          m_ipc = m_pc;
          m_valid = 1'b1;
          m_pc = (m_pc == 8'h8B) ? 8'h00 : m_pc + 8'd1;
        end
      end else if (instr_ready) begin
        m_cnt = m_cnt + 8'd1;
        m_valid = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; halt = 0; mem_busy = 0;
    redirect = 0; redirect_pc = 0; instr_ready = 0;
    step();
    step();
    n_vec++;
    if ({instr_out, instr_pc, fetch_count} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_regs got %h/%h/%h want 0/0/0",
               instr_out, instr_pc, fetch_count);
    end
    n_vec++;
    if ({instr_valid, fault} !== 2'b00 || mem_addr !== 8'h00) begin
      n_err++;
      $display("FAIL reset_flags got v%b f%b a%h want 0 0 00",
               instr_valid, fault, mem_addr);
    end
    n_vec++;
    if (mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL reset_read got %b want 0", mem_read);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp [4];
    exp[0] = 8'hA1; exp[1] = 8'hB2;
    exp[2] = 8'hC3; exp[3] = 8'hD4;
    reset = 0; instr_ready = 1;
    #1;
    n_vec++;
    if (mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL seq_first_read got %b want 1", mem_read);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_vec++;
      if (instr_valid !== (k % 2 == 0)) begin
        n_err++;
        $display("FAIL seq_valid k=%0d got %b want %b",
                 k, instr_valid, (k % 2 == 0));
      end
      if (k % 2 == 0) begin
        n_vec++;
        if (instr_out !== exp[k/2] || instr_pc !== 8'(k/2)) begin
          n_err++;
          $display("FAIL seq_instr k=%0d got %h@%h want %h@%h",
                   k, instr_out, instr_pc, exp[k/2], 8'(k/2));
        end
      end
    end
    n_vec++;
    if (fetch_count !== 8'd4 || mem_addr !== 8'h04) begin
      n_err++;
      $display("FAIL seq_count got %0d a%h want 4 a04",
               fetch_count, mem_addr);
    end
  endtask

  task automatic test_wrap();
    instr_ready = 0;
    redirect = 1; redirect_pc = 8'h8B;
    step();
    redirect = 0;
    n_vec++;
    if (instr_valid !== 1'b0 || mem_addr !== 8'h8B) begin
      n_err++;
      $display("FAIL wrap_redir got v%b a%h want 0 8b",
               instr_valid, mem_addr);
    end
    step();
    n_vec++;
    if (instr_pc !== 8'h8B || instr_out !== 8'h5A
        || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_fetch got %h@%h v%b want 5a@8b v1",
               instr_out, instr_pc, instr_valid);
    end
    n_vec++;
    if (mem_addr !== 8'h00 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_next got a%h f%b want 00 0",
               mem_addr, fault);
    end
  endtask

  task automatic test_stall();
    logic [7:0] cnt0;
    cnt0 = fetch_count;
    instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (mem_read !== 1'b0) begin
        n_err++;
        $display("FAIL stall_read i=%0d got %b want 0", i, mem_read);
      end
      step();
      n_vec++;
      if (instr_valid !== 1'b1 || instr_out !== 8'h5A
          || fetch_count !== cnt0) begin
        n_err++;
        $display("FAIL stall_hold i=%0d got v%b %h c%0d want 1 5a %0d",
                 i, instr_valid, instr_out, fetch_count, cnt0);
      end
    end
    instr_ready = 1;
    step();
    instr_ready = 0;
    n_vec++;
    if (fetch_count !== cnt0 + 8'd1 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_accept got c%0d v%b want %0d 0",
               fetch_count, instr_valid, cnt0 + 8'd1);
    end
    #1;
    n_vec++;
    if (mem_read !== 1'b1 || mem_addr !== 8'h00) begin
      n_err++;
      $display("FAIL stall_resume got r%b a%h want 1 00",
               mem_read, mem_addr);
    end
  endtask

  task automatic test_busy();
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (mem_read !== 1'b0) begin
        n_err++;
        $display("FAIL busy_read i=%0d got %b want 0", i, mem_read);
      end
      step();
      n_vec++;
      if (mem_addr !== 8'h00 || instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL busy_pc i=%0d got a%h v%b want 00 0",
                 i, mem_addr, instr_valid);
      end
    end
    mem_busy = 0;
    step();
    n_vec++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h00
        || instr_out !== 8'hA1) begin
      n_err++;
      $display("FAIL busy_retry got v%b %h@%h want 1 a1@00",
               instr_valid, instr_out, instr_pc);
    end
  endtask

  task automatic test_redirect();
    logic [7:0] cnt0;
    cnt0 = fetch_count;
    redirect = 1; redirect_pc = 8'h40; instr_ready = 1;
    step();
    redirect = 0; instr_ready = 0;
    n_vec++;
    if (instr_valid !== 1'b0 || fetch_count !== cnt0
        || mem_addr !== 8'h40) begin
      n_err++;
      $display("FAIL redir got v%b c%0d a%h want 0 %0d 40",
               instr_valid, fetch_count, mem_addr, cnt0);
    end
  endtask

  task automatic test_halt();
    logic [7:0] cnt0;
    step();
    cnt0 = fetch_count;
    halt = 1; instr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (mem_read !== 1'b0) begin
        n_err++;
        $display("FAIL halt_read i=%0d got %b want 0", i, mem_read);
      end
      step();
      n_vec++;
      if (fetch_count !== cnt0 || instr_valid !== 1'b1
          || instr_out !== 8'h77 || mem_addr !== 8'h41) begin
        n_err++;
        $display("FAIL halt_frozen i=%0d got c%0d v%b %h a%h want %0d 1 77 41",
                 i, fetch_count, instr_valid, instr_out, mem_addr, cnt0);
      end
    end
    halt = 0;
    step();
    instr_ready = 0;
    n_vec++;
    if (fetch_count !== cnt0 + 8'd1 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL halt_release got c%0d v%b want %0d 0",
               fetch_count, instr_valid, cnt0 + 8'd1);
    end
  endtask

  task automatic test_fault();
    logic [7:0] cnt0;
    step();
    cnt0 = fetch_count;
    redirect = 1; redirect_pc = 8'h90; instr_ready = 1;
    step();
    redirect = 0;
    n_vec++;
    if (fault !== 1'b1 || instr_valid !== 1'b0
        || mem_addr !== 8'h42 || fetch_count !== cnt0) begin
      n_err++;
      $display("FAIL fault_enter got f%b v%b a%h c%0d want 1 0 42 %0d",
               fault, instr_valid, mem_addr, fetch_count, cnt0);
    end
    for (int i = 0; i < 6; i++) begin
      redirect = 1'($urandom_range(0, 1));
      redirect_pc = 8'h10;
      instr_ready = 1'($urandom_range(0, 1));
      #1;
      n_vec++;
      if (mem_read !== 1'b0) begin
        n_err++;
        $display("FAIL fault_read i=%0d got %b want 0", i, mem_read);
      end
      step();
      n_vec++;
      if (fault !== 1'b1 || instr_valid !== 1'b0
          || mem_addr !== 8'h42) begin
        n_err++;
        $display("FAIL fault_sticky i=%0d got f%b v%b a%h want 1 0 42",
                 i, fault, instr_valid, mem_addr);
      end
    end
    redirect = 0; instr_ready = 0;
  endtask

  task automatic test_fault_reset();
    reset = 1;
    step();
    reset = 0;
    n_vec++;
    if ({fault, instr_valid} !== 2'b00
        || {instr_out, instr_pc, fetch_count, mem_addr} !== 32'h0) begin
      n_err++;
      $display("FAIL freset got f%b v%b %h %h %h a%h want all 0",
               fault, instr_valid, instr_out, instr_pc,
               fetch_count, mem_addr);
    end
    #1;
    n_vec++;
    if (mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL freset_read got %b want 1", mem_read);
    end
    step();
    n_vec++;
    if (instr_pc !== 8'h00 || instr_out !== 8'hA1
        || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL freset_fetch got %h@%h v%b want a1@00 1",
               instr_out, instr_pc, instr_valid);
    end
  endtask

  task automatic test_random();
    logic exp_rd;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      halt = ($urandom_range(0, 5) == 0);
      mem_busy = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0)
                    ? 8'($urandom_range(8'h8C, 8'hFF))
                    : 8'($urandom_range(0, 8'h8B));
      instr_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rd = !reset && !halt && !mem_busy && !m_fault && !m_valid;
      n_vec++;
      if (mem_read !== exp_rd || mem_addr !== m_pc) begin
        n_err++;
        $display("FAIL rnd_bus i=%0d got r%b a%h want r%b a%h",
                 i, mem_read, mem_addr, exp_rd, m_pc);
      end
      step();
      n_vec++;
      if (instr_out !== m_ir || instr_pc !== m_ipc
          || instr_valid !== m_valid || fetch_count !== m_cnt
          || fault !== m_fault) begin
        n_err++;
        $display("FAIL rnd_state i=%0d got %h@%h v%b c%0d f%b want %h@%h v%b c%0d f%b",
                 i, instr_out, instr_pc, instr_valid, fetch_count,
                 fault, m_ir, m_ipc, m_valid, m_cnt, m_fault);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_pc = 0; m_ir = 0; m_ipc = 0; m_cnt = 0;
    m_valid = 0; m_fault = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    mem[8'h00] = 8'hA1; mem[8'h01] = 8'hB2;
    mem[8'h02] = 8'hC3; mem[8'h03] = 8'hD4;
    mem[8'h8B] = 8'h5A; mem[8'h40] = 8'h77;
    test_reset();
    test_sequence();
    test_wrap();
    test_stall();
    test_busy();
    test_redirect();
    test_halt();
    test_fault();
    test_fault_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
